menu_overlay: RTL and testbench

- Pixel-stage consumer of the 640x480 VGA timing generator. Takes its x/y/valid/hsync/vsync/newframe and its 25 MHz strobe.
- Renders a vertical list of N_ITEMS menu boxes with a highlighted cursor item, and outputs 12-bit RGB with sync delayed to match.
- Up/down buttons move the cursor, applied only at frame boundaries so no frame tears. The select button reports the chosen item.

---
 rtl/menu_pkg.sv | 44 ++++
 rtl/menu_overlay_btn_edge.sv | 28 ++
 rtl/menu_overlay.sv | 175 +++++++++++++++++
 tb/tb_menu_overlay.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared constants and types for the menu overlay pixel stage.
package menu_pkg;

  localparam int IDX_W = 3;

  // 12-bit RGB colours, 4 bits per channel, red in the top nibble.
  localparam logic [11:0] COL_BLANK  = 12'h000;
  localparam logic [11:0] COL_BG     = 12'h001;
  localparam logic [11:0] COL_ITEM   = 12'h448;
  localparam logic [11:0] COL_HILITE = 12'hFF0;

  // Default menu geometry for a 640x480 raster.
  localparam int DEF_N_ITEMS  = 6;
  localparam int DEF_MENU_X0  = 160;
  localparam int DEF_MENU_Y0  = 120;
  localparam int DEF_ITEM_W   = 320;
  localparam int DEF_ITEM_H   = 40;
  localparam int DEF_ITEM_GAP = 8;
  localparam int DEF_WRAP     = 1;

  // What the first pixel stage remembers about one pixel.
  typedef struct packed {
    logic box;
    logic sel;
    logic valid;
    logic hs;
    logic vs;
  } stage1_t;

  // Colour priority: blanking, then highlighted box, then plain box, then background.
  function automatic logic [11:0] colour_of(input stage1_t s);
    logic [11:0] c;
    c = COL_BG;
    if (!s.valid) begin
      c = COL_BLANK;
    end else if (s.box && s.sel) begin
      c = COL_HILITE;
    end else if (s.box) begin
      c = COL_ITEM;
    end
    return c;
  endfunction

endpackage

// File: rtl/menu_overlay_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the raw button and remember the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/menu_overlay.sv
// Menu overlay: draws a vertical list of boxes with a highlighted cursor item
// on top of the VGA timing stream and delays the syncs to match the colour.
module menu_overlay
  import menu_pkg::*;
#(
  parameter int N_ITEMS  = DEF_N_ITEMS,
  parameter int MENU_X0  = DEF_MENU_X0,
  parameter int MENU_Y0  = DEF_MENU_Y0,
  parameter int ITEM_W   = DEF_ITEM_W,
  parameter int ITEM_H   = DEF_ITEM_H,
  parameter int ITEM_GAP = DEF_ITEM_GAP,
  parameter int WRAP     = DEF_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             valid,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             newframe,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [IDX_W-1:0] cursor,
  output logic [IDX_W-1:0] sel_item,
  output logic             sel_strobe
);

  localparam int P = ITEM_H + ITEM_GAP;
  localparam logic [9:0]       X_LO     = 10'(MENU_X0);
  localparam logic [9:0]       X_HI     = 10'(MENU_X0 + ITEM_W);
  localparam logic [9:0]       Y_TOP    = 10'(MENU_Y0);
  localparam logic [9:0]       BOX_H    = 10'(ITEM_H);
  localparam logic [9:0]       P_LAST   = 10'(P - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);
  localparam stage1_t          S1_IDLE  = '{box: 1'b0, sel: 1'b0, valid: 1'b0, hs: 1'b1, vs: 1'b1};

  logic up_evt, dn_evt, sel_evt;

  btn_edge u_up  (.clk(clk), .rst(rst), .btn_i(btn_up),   .pulse_o(up_evt));
  btn_edge u_dn  (.clk(clk), .rst(rst), .btn_i(btn_down), .pulse_o(dn_evt));
  btn_edge u_sel (.clk(clk), .rst(rst), .btn_i(btn_sel),  .pulse_o(sel_evt));

  logic             pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
  logic [IDX_W-1:0] cursor_q, cursor_d, sel_item_q, sel_item_d;
  logic             sel_strobe_q, sel_strobe_d;
  logic             in_rows_q, in_rows_d;
  logic [IDX_W-1:0] item_idx_q, item_idx_d;
  logic [9:0]       line_cnt_q, line_cnt_d;
  logic             in_box;
  stage1_t          s1_q, s1_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d;

  // Cursor moves are collected during the frame and applied only at frame start;
  // an edge that lands on the newframe cycle itself waits for the next frame.
  always_comb begin
    pend_up_d    = pend_up_q | up_evt;
    pend_dn_d    = pend_dn_q | dn_evt;
    cursor_d     = cursor_q;
    sel_strobe_d = sel_evt;
    sel_item_d   = sel_evt ? cursor_q : sel_item_q;
    if (newframe) begin
      pend_up_d = up_evt;
      pend_dn_d = dn_evt;
      if (pend_up_q && !pend_dn_q) begin
        if (cursor_q != '0) begin
          cursor_d = cursor_q - IDX_W'(1);
        end else if (WRAP != 0) begin
          cursor_d = LAST_IDX;
        end
      end else if (pend_dn_q && !pend_up_q) begin
        if (cursor_q != LAST_IDX) begin
          cursor_d = cursor_q + IDX_W'(1);
        end else if (WRAP != 0) begin
          cursor_d = '0;
        end
      end
    end
  end

  // Row tracker: counts lines inside the menu band at the start of each line,
  // so the current item and in-box state need no division.
  always_comb begin
    in_rows_d  = in_rows_q;
    item_idx_d = item_idx_q;
    line_cnt_d = line_cnt_q;
    if (newframe) begin
      in_rows_d  = 1'b0;
      item_idx_d = '0;
      line_cnt_d = '0;
    end else if (pix_en && (x == 10'd0)) begin
      if (y == Y_TOP) begin
        in_rows_d  = 1'b1;
        item_idx_d = '0;
        line_cnt_d = '0;
      end else if (in_rows_q) begin
        if (line_cnt_q == P_LAST) begin
          line_cnt_d = '0;
          item_idx_d = item_idx_q + IDX_W'(1);
          if (item_idx_q == LAST_IDX) begin
            in_rows_d = 1'b0;
          end
        end else begin
          line_cnt_d = line_cnt_q + 10'd1;
        end
      end
    end
  end

  assign in_box = in_rows_q && (line_cnt_q < BOX_H) && (x >= X_LO) && (x < X_HI);

  // Two-stage pixel pipeline that only advances on the pixel strobe.
  always_comb begin
    s1_d  = s1_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pix_en) begin
      s1_d  = '{box: in_box, sel: (item_idx_q == cursor_q), valid: valid,
                hs: hsync_in, vs: vsync_in};
      rgb_d = colour_of(s1_q);
      hs_d  = s1_q.hs;
      vs_d  = s1_q.vs;
    end
  end

  // State registers; reset discards pending moves and flushes the pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_up_q    <= 1'b0;
      pend_dn_q    <= 1'b0;
      cursor_q     <= '0;
      sel_item_q   <= '0;
      sel_strobe_q <= 1'b0;
      in_rows_q    <= 1'b0;
      item_idx_q   <= '0;
      line_cnt_q   <= '0;
      s1_q         <= S1_IDLE;
      rgb_q        <= COL_BLANK;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      pend_up_q    <= pend_up_d;
      pend_dn_q    <= pend_dn_d;
      cursor_q     <= cursor_d;
      sel_item_q   <= sel_item_d;
      sel_strobe_q <= sel_strobe_d;
      in_rows_q    <= in_rows_d;
      item_idx_q   <= item_idx_d;
      line_cnt_q   <= line_cnt_d;
      s1_q         <= s1_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign cursor     = cursor_q;
  assign sel_item   = sel_item_q;
  assign sel_strobe = sel_strobe_q;

endmodule

// File: tb/tb_menu_overlay.sv
// Self-checking bench: a wrapping and a saturating menu_overlay share one
// sparse, randomized raster; a behavioural model predicts every output.
module tb_menu_overlay;

  localparam int N  = 6;
  localparam int X0 = 160;
  localparam int Y0 = 120;
  localparam int W  = 320;
  localparam int H  = 40;
  localparam int P  = 48;

  logic       clk = 1'b0;
  logic       rst, pix_en, valid, hsync_in, vsync_in, newframe;
  logic       btn_up, btn_down, btn_sel;
  logic [9:0] x, y;
  logic [3:0] red_w, green_w, blue_w, red_s, green_s, blue_s;
  logic       hs_w, vs_w, hs_s, vs_s, str_w, str_s;
  logic [2:0] cur_w, cur_s, si_w, si_s;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  menu_overlay #(.WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .newframe(newframe),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .red(red_w), .green(green_w), .blue(blue_w),
    .hsync_out(hs_w), .vsync_out(vs_w),
    .cursor(cur_w), .sel_item(si_w), .sel_strobe(str_w));

  menu_overlay #(.WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .newframe(newframe),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .red(red_s), .green(green_s), .blue(blue_s),
    .hsync_out(hs_s), .vsync_out(vs_s),
    .cursor(cur_s), .sel_item(si_s), .sel_strobe(str_s));

  // Model state; index 0 = wrapping instance, 1 = saturating instance.
  int          m_cur[2];
  int          m_si[2];
  bit          m_str[2];
  logic [13:0] m_p1[2];
  logic [13:0] m_out[2];
  bit          pend_up, pend_dn, armed, m_ready;
  logic [2:0]  hu, hd, hsl;
  bit          lvl_rst, lvl_up, lvl_dn, lvl_sel;
  int          nstr[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Colour of a pixel straight from the geometry rules.
  function automatic logic [11:0] exp_colour(input int px, input int py, input bit vld,
                                             input int cur, input bit arm);
    int dy;
    dy = py - Y0;
    if (!vld) return 12'h000;
    if (arm && dy >= 0 && dy < N * P && (dy % P) < H && px >= X0 && px < X0 + W)
      return (dy / P == cur) ? 12'hFF0 : 12'h448;
    return 12'h001;
  endfunction

  function automatic int move(input int c, input bit up, input bit dn, input bit wrap);
    if (up && !dn) return (c == 0) ? (wrap ? N - 1 : 0) : c - 1;
    if (dn && !up) return (c == N - 1) ? (wrap ? 0 : N - 1) : c + 1;
    return c;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic step();
    bit ue, de, se;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cur[i] = 0; m_si[i] = 0; m_str[i] = 1'b0;
        m_p1[i] = {12'h000, 2'b11}; m_out[i] = {12'h000, 2'b11};
      end
      pend_up = 1'b0; pend_dn = 1'b0; armed = 1'b0;
      hu = '0; hd = '0; hsl = '0;
      m_ready = 1'b1;
      return;
    end
    // A button press is seen two edges after it is first sampled high.
    ue = hu[1] & ~hu[2];
    de = hd[1] & ~hd[2];
    se = hsl[1] & ~hsl[2];
    hu = {hu[1:0], btn_up};
    hd = {hd[1:0], btn_down};
    hsl = {hsl[1:0], btn_sel};
    for (int i = 0; i < 2; i++) begin
      m_str[i] = se;
      if (se) m_si[i] = m_cur[i];
      if (pix_en) begin
        m_out[i] = m_p1[i];
        m_p1[i] = {exp_colour(int'(x), int'(y), valid, m_cur[i], armed), hsync_in, vsync_in};
      end
    end
    if (newframe) armed = 1'b0;
    else if (pix_en && x == 10'd0 && y == 10'(Y0)) armed = 1'b1;
    if (newframe) begin
      m_cur[0] = move(m_cur[0], pend_up, pend_dn, 1'b1);
      m_cur[1] = move(m_cur[1], pend_up, pend_dn, 1'b0);
      pend_up = ue; pend_dn = de;
    end else begin
      pend_up = pend_up | ue; pend_dn = pend_dn | de;
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("pix_w", 32'({red_w, green_w, blue_w, hs_w, vs_w}), 32'(m_out[0]));
      check("pix_s", 32'({red_s, green_s, blue_s, hs_s, vs_s}), 32'(m_out[1]));
      check("ctl_w", 32'({cur_w, si_w, str_w}), 32'({3'(m_cur[0]), 3'(m_si[0]), m_str[0]}));
      check("ctl_s", 32'({cur_s, si_s, str_s}), 32'({3'(m_cur[1]), 3'(m_si[1]), m_str[1]}));
      if (str_w) nstr[0]++;
      if (str_s) nstr[1]++;
    end
  end

  task automatic cyc(input bit pe, input int px, input int py, input bit nf);
    @(negedge clk);
    rst = lvl_rst;
    pix_en = pe;
    newframe = nf;
    if (pe) begin
      x = 10'(px);
      y = 10'(py);
      valid = (px < 640 && py < 480);
      hsync_in = !(px >= 656 && px < 752);
      vsync_in = !(py >= 490 && py < 492);
    end
    btn_up = lvl_up;
    btn_down = lvl_dn;
    btn_sel = lvl_sel;
    @(posedge clk);
    step();
  endtask

  task automatic reset_checks();
    #1;
    check("rst_rgb", 32'({red_w, green_w, blue_w}), 32'h000);
    check("rst_sync", 32'({hs_w, vs_w}), 32'h3);
    check("rst_cur", 32'(cur_w), 32'd0);
    check("rst_str", 32'(str_w), 32'd0);
  endtask

  // One frame of sparse pixels: a few fixed columns plus one random column per line.
  task automatic run_frame(input int up_l, input int dn_l, input int sel_l, input int sel_n,
                           input int rst_l, input bit sel_nf, input int n_lines);
    int xs[8];
    for (int ly = 0; ly < n_lines; ly++) begin
      lvl_up  = (up_l >= 0 && ly >= up_l && ly < up_l + 2);
      lvl_dn  = (dn_l >= 0 && ly >= dn_l && ly < dn_l + 2);
      lvl_sel = (sel_l >= 0 && ly >= sel_l && ly < sel_l + sel_n);
      if (ly == rst_l) begin
        lvl_rst = 1'b0;
        repeat (3) cyc(1'b0, 0, ly, 1'b0);
        reset_checks();
        lvl_rst = 1'b1;
      end
      xs = '{0, 159, 160, 200, 479, 480, 700, int'($urandom_range(799, 1))};
      for (int k = 0; k < 8; k++) begin
        cyc(1'b1, xs[k], ly, (ly == 0 && k == 0));
        if ($urandom_range(1, 0) == 1) cyc(1'b0, xs[k], ly, 1'b0);
      end
    end
    if (sel_nf) begin
      lvl_sel = 1'b1;
      cyc(1'b0, 0, 0, 1'b0);
      cyc(1'b0, 0, 0, 1'b0);
    end
    #1;
  endtask

  initial begin
    int base_w, base_s;
    rst = 1'b0; pix_en = 1'b0; x = '0; y = '0; valid = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; newframe = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    lvl_rst = 1'b0; lvl_up = 1'b0; lvl_dn = 1'b0; lvl_sel = 1'b0;
    nstr[0] = 0; nstr[1] = 0;

    // Hand-computed pixel colours pinning the model's geometry.
    check("lit_box0",  32'(exp_colour(160, 120, 1'b1, 0, 1'b1)), 32'hFF0);
    check("lit_x159",  32'(exp_colour(159, 120, 1'b1, 0, 1'b1)), 32'h001);
    check("lit_x479",  32'(exp_colour(479, 120, 1'b1, 0, 1'b1)), 32'hFF0);
    check("lit_x480",  32'(exp_colour(480, 120, 1'b1, 0, 1'b1)), 32'h001);
    check("lit_item1", 32'(exp_colour(200, 168, 1'b1, 0, 1'b1)), 32'h448);
    check("lit_gap",   32'(exp_colour(200, 160, 1'b1, 0, 1'b1)), 32'h001);
    check("lit_blank", 32'(exp_colour(200, 130, 1'b0, 0, 1'b1)), 32'h000);

    repeat (4) cyc(1'b0, 0, 0, 1'b0);
    reset_checks();
    lvl_rst = 1'b1;

    run_frame(-1, 200, -1, 0, -1, 1'b0, 525);   // down pressed mid-frame
    check("f0_cur_w", 32'(cur_w), 32'd0);
    run_frame(100, 300, -1, 0, -1, 1'b0, 525);  // up and down in one frame
    check("f1_cur_w", 32'(cur_w), 32'd1);
    run_frame(200, -1, -1, 0, -1, 1'b0, 525);
    check("f2_cur_w", 32'(cur_w), 32'd1);
    run_frame(200, -1, -1, 0, -1, 1'b0, 525);
    check("f3_cur_w", 32'(cur_w), 32'd0);
    check("f3_cur_s", 32'(cur_s), 32'd0);
    run_frame(200, -1, -1, 0, -1, 1'b0, 525);
    check("f4_wrap", 32'(cur_w), 32'd5);
    check("f4_sat",  32'(cur_s), 32'd0);
    run_frame(200, -1, -1, 0, -1, 1'b0, 525);
    check("f5_cur_w", 32'(cur_w), 32'd4);
    base_w = nstr[0]; base_s = nstr[1];
    run_frame(-1, 300, 100, 90, -1, 1'b1, 525); // long select hold, select on newframe
    check("f6_cur_w", 32'(cur_w), 32'd3);
    check("f6_sel_w", 32'(si_w), 32'd3);
    check("f6_sel_s", 32'(si_s), 32'd0);
    check("f6_pulses_w", 32'(nstr[0] - base_w), 32'd1);
    check("f6_pulses_s", 32'(nstr[1] - base_s), 32'd1);
    run_frame(-1, -1, -1, 0, -1, 1'b0, 525);
    check("f7_cur_w", 32'(cur_w), 32'd4);
    check("f7_cur_s", 32'(cur_s), 32'd1);
    check("f7_sel_w", 32'(si_w), 32'd3);
    check("f7_sel_s", 32'(si_s), 32'd0);
    run_frame(-1, 100, -1, 0, 300, 1'b0, 525);  // pending move then reset mid-frame
    run_frame(-1, -1, -1, 0, -1, 1'b0, 10);
    check("f9_cur_w", 32'(cur_w), 32'd0);
    check("f9_cur_s", 32'(cur_s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
